// File: rtl/pacman_pkg.sv
// Shared types and constants for the pacman ROM download path.
// The load FSM state type lives here so the controller and any monitors agree on it.
package pacman_pkg;

  typedef enum logic [2:0] {
    BOOT,
    LOAD,
    HOLD,
    RUN,
    ERROR
  } load_state_t;

  localparam int unsigned DN_ADDR_W      = 16;
  localparam logic [16:0] ROM_MIN_SIZE   = 17'h08000;
  localparam logic [16:0] BYTE_COUNT_MAX = 17'h1FFFF;

endpackage

// File: rtl/reset_stretch.sv
// Loadable down-counter that keeps the core in reset for HOLD_CYC cycles.
// busy stays high until the count has drained to zero.
module reset_stretch #(
  parameter int unsigned HOLD_CYC = 1024
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic busy
);

  localparam int unsigned CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(HOLD_CYC - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/rom_load_ctrl.sv
// Sequences the hps_io ROM download into the pacman dn_* port and owns core_reset.
// The core is held in reset until a full-size image has arrived, then for HOLD_CYC cycles.
module rom_load_ctrl
  import pacman_pkg::*;
#(
  parameter int unsigned ADDR_W   = DN_ADDR_W,
  parameter logic [16:0] MIN_SIZE = ROM_MIN_SIZE,
  parameter int unsigned HOLD_CYC = 1024
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              user_reset,
  output logic              core_reset,
  output logic              dn_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              loaded,
  output logic              load_err,
  output logic [16:0]       byte_count
);

  localparam logic [25:0] ADDR_LIM = 26'(1) << ADDR_W;

  load_state_t state, next_state;
  logic        dl_q;
  logic        start_ev, end_ev, accept;
  logic        hold_load, hold_busy;

  assign start_ev = ioctl_download & ~dl_q;
  assign end_ev   = ~ioctl_download & dl_q;
  assign accept   = ioctl_wr & ioctl_download & ({1'b0, ioctl_addr} < ADDR_LIM);

  reset_stretch #(.HOLD_CYC(HOLD_CYC)) u_stretch (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (hold_load),
    .dec     (state == HOLD),
    .busy    (hold_busy)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= BOOT;
    else       state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    hold_load  = 1'b0;
    if (start_ev) begin
      next_state = LOAD;
    end else begin
      case (state)
        BOOT, ERROR: ;
        LOAD: begin
          if (end_ev) begin
            if (byte_count >= MIN_SIZE) begin
              next_state = HOLD;
              hold_load  = 1'b1;
            end else begin
              next_state = ERROR;
            end
          end
        end
        HOLD: begin
          if (user_reset)      hold_load  = 1'b1;
          else if (!hold_busy) next_state = RUN;
        end
        RUN: begin
          if (user_reset) begin
            next_state = HOLD;
            hold_load  = 1'b1;
          end
        end
        default: next_state = BOOT;
      endcase
    end
  end

  // Status outputs decode next_state so they change on the same edge as the state.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      core_reset <= 1'b1;
      loaded     <= 1'b0;
      load_err   <= 1'b0;
      dn_wr      <= 1'b0;
      dn_addr    <= '0;
      dn_data    <= '0;
      byte_count <= '0;
    end else begin
      dl_q       <= ioctl_download;
      core_reset <= (next_state != RUN);
      dn_wr      <= accept;
      if (accept) begin
        dn_addr <= ioctl_addr[ADDR_W-1:0];
        dn_data <= ioctl_dout;
      end
      if (start_ev) begin
        byte_count <= accept ? 17'd1 : 17'd0;
      end else if (accept && (byte_count != BYTE_COUNT_MAX)) begin
        byte_count <= byte_count + 17'd1;
      end
      case (next_state)
        LOAD: begin
          loaded   <= 1'b0;
          load_err <= 1'b0;
        end
        RUN:  loaded <= 1'b1;
        ERROR: begin
          loaded   <= 1'b0;
          load_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: the driver queues expected dn_* writes,
// a negedge monitor pops and compares them; status outputs are checked directly.
module tb_rom_load_ctrl;
  import pacman_pkg::*;

  localparam int HOLD_N = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        user_reset;
  logic        core_reset;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        loaded;
  logic        load_err;
  logic [16:0] byte_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          at;
  } exp_wr_t;

  exp_wr_t sb[$];
  exp_wr_t e;

  rom_load_ctrl #(
    .ADDR_W   (16),
    .MIN_SIZE (17'h08000),
    .HOLD_CYC (HOLD_N)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .core_reset     (core_reset),
    .dn_wr          (dn_wr),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .loaded         (loaded),
    .load_err       (load_err),
    .byte_count     (byte_count)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
  endfunction

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit ok);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (ok) sb.push_back('{addr: a[15:0], data: d, at: cyc + 1});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic load_bytes(input int base, input int n);
    for (int i = 0; i < n; i++) wr(25'(base + i), pat(base + i), 1'b1);
  endtask

  // Monitor: every dn_wr must match the head of the queue, one cycle after issue.
  always @(negedge clk_sys) begin
    if (reset === 1'b0) begin
      if (dn_wr === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dn_wr_unexpected: got dn_wr=1 addr=%0h expected no write (cycle %0d)", dn_addr, cyc);
        end else begin
          e = sb.pop_front();
          check("dn_wr_cycle", cyc, e.at);
          check("dn_wr_addr_data", {dn_addr, dn_data}, {e.addr, e.data});
        end
      end else if (sb.size() > 0 && cyc >= sb[0].at) begin
        e = sb.pop_front();
        total++;
        bad++;
        $display("FAIL dn_wr_missing: got dn_wr=0 expected write addr=%0h at cycle %0d", e.addr, e.at);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    user_reset     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values, then a long idle with no download.
    @(negedge clk_sys);
    check("rst_core_reset", core_reset, 1);
    check("rst_loaded", loaded, 0);
    check("rst_load_err", load_err, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_dn", {dn_wr, dn_addr, dn_data}, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (1000) tick();
      @(negedge clk_sys);
      check("idle_core_reset", core_reset, 1);
      check("idle_loaded", loaded, 0);
    end

    // Full 0x8000-byte image.
    ioctl_download = 1'b1;
    tick();
    tick();
    load_bytes(0, 32'h8000);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("full_byte_count", byte_count, 17'h08000);
    check("full_core_reset_end", core_reset, 1);
    repeat (HOLD_N) tick();
    @(negedge clk_sys);
    check("full_hold_last", core_reset, 1);
    check("full_hold_loaded", loaded, 0);
    tick();
    @(negedge clk_sys);
    check("full_release", core_reset, 0);
    check("full_loaded", loaded, 1);

    // user_reset in RUN for 5 cycles.
    tick();
    user_reset = 1'b1;
    tick();
    @(negedge clk_sys);
    check("ureset_assert", core_reset, 1);
    check("ureset_loaded_kept", loaded, 1);
    repeat (3) tick();
    tick();
    user_reset = 1'b0;
    repeat (HOLD_N - 1) tick();
    @(negedge clk_sys);
    check("ureset_hold_last", core_reset, 1);
    tick();
    @(negedge clk_sys);
    check("ureset_release", core_reset, 0);
    check("ureset_loaded", loaded, 1);

    // New download while running, aborted short.
    tick();
    ioctl_download = 1'b1;
    tick();
    @(negedge clk_sys);
    check("restart_core_reset", core_reset, 1);
    check("restart_loaded", loaded, 0);
    check("restart_byte_count", byte_count, 0);
    load_bytes(32'h100, 4);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("abort_byte_count", byte_count, 4);
    tick();
    @(negedge clk_sys);
    check("abort_load_err", load_err, 1);

    // Short 0x100-byte image.
    ioctl_download = 1'b1;
    tick();
    @(negedge clk_sys);
    check("short_err_cleared", load_err, 0);
    load_bytes(32'h4000, 32'h100);
    ioctl_download = 1'b0;
    tick();
    @(negedge clk_sys);
    check("short_load_err", load_err, 1);
    check("short_core_reset", core_reset, 1);
    check("short_loaded", loaded, 0);
    check("short_byte_count", byte_count, 17'h00100);
    user_reset = 1'b1;
    repeat (3) tick();
    user_reset = 1'b0;
    wr(25'h20, 8'h11, 1'b0);
    wr(25'h21, 8'h22, 1'b0);
    repeat (HOLD_N + 4) tick();
    @(negedge clk_sys);
    check("err_core_reset_kept", core_reset, 1);
    check("err_load_err_kept", load_err, 1);
    check("err_idle_wr_ignored", byte_count, 17'h00100);

    // Valid image with out-of-range writes interleaved.
    ioctl_download = 1'b1;
    tick();
    tick();
    load_bytes(0, 32'h4000);
    wr(25'h10000, 8'hAA, 1'b0);
    wr(25'h10005, 8'hBB, 1'b0);
    @(negedge clk_sys);
    check("oor_dn_hold", {dn_addr, dn_data}, {16'h3FFF, pat(32'h3FFF)});
    check("oor_not_counted", byte_count, 17'h04000);
    load_bytes(32'h4000, 32'h4000);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("final_byte_count", byte_count, 17'h08000);
    check("final_err_cleared", load_err, 0);
    repeat (HOLD_N) tick();
    @(negedge clk_sys);
    check("final_hold_last", core_reset, 1);
    tick();
    @(negedge clk_sys);
    check("final_release", core_reset, 0);
    check("final_loaded", loaded, 1);

    repeat (3) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
